// File: rtl/encoder8_3_if.sv
// encoder8_3_if: vector input and index output handshakes of the 8-to-3 encoder
interface encoder8_3_if;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic       A;
    logic       B;
    logic       C;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero_err;
    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, A, B, C, out_valid, out_last, zero_err
    );
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, A, B, C, out_valid, out_last, zero_err
    );
endinterface

// File: rtl/encoder8_3_seq.sv
// encoder8_3_seq: sequential 8-to-3 encoder, emits the index of every set bit of a vector
module encoder8_3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    encoder8_3_if.slave    bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    logic [0:0] r_state;
    logic [7:0] r_pending;
    logic       r_zero_err;
    logic [2:0] w_idx;
    logic [7:0] w_onehot;
    logic       w_last;
    logic       w_emit;
    // Priority-select the next index: the last match in scan order wins
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pending[MSB_FIRST ? i : 7 - i]) w_idx = MSB_FIRST ? 3'(i) : 3'(7 - i);
        end
    end
    assign w_emit        = (r_state == EMIT);
    assign w_onehot      = 8'h01 << w_idx;
    assign w_last        = (r_pending != 8'h00) && ((r_pending & (r_pending - 8'h01)) == 8'h00);
    assign bus.in_ready  = !w_emit;
    assign bus.out_valid = w_emit;
    assign bus.out_last  = w_emit && w_last;
    assign {bus.A, bus.B, bus.C} = w_emit ? w_idx : 3'd0;
    assign bus.zero_err  = r_zero_err;
    // Accept vectors in IDLE, retire one set bit per accepted output beat in EMIT
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_pending  <= 8'h00;
            r_zero_err <= 1'b0;
        end else begin
            r_zero_err <= !w_emit && bus.in_valid && (bus.in_vec == 8'h00);
            if (!w_emit) begin
                if (bus.in_valid && bus.in_vec != 8'h00) begin
                    r_pending <= bus.in_vec;
                    r_state   <= EMIT;
                end
            end else if (bus.out_ready) begin
                r_pending <= r_pending & ~w_onehot;
                if (w_last) r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_encoder8_3_seq.sv
// tb_encoder8_3_seq: checks both emission orders against a queue-based reference model
module tb_encoder8_3_seq;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    bit zexp = 1'b0;

    always #5 sys_clk = ~sys_clk;

    encoder8_3_if bus0();
    encoder8_3_if bus1();

    encoder8_3_seq #(.MSB_FIRST(1'b0)) dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0));
    encoder8_3_seq #(.MSB_FIRST(1'b1)) dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] vec, input logic valid, input logic ready, input logic rst);
        if (rst) begin
            q0.delete();
            q1.delete();
            zexp = 1'b0;
        end else begin
            zexp = (q0.size() == 0) && valid && (vec == 8'h00);
            if (q0.size() == 0) begin
                if (valid && vec != 8'h00)
                    for (int i = 0; i < 8; i++)
                        if (vec[i]) begin
                            q0.push_back(3'(i));
                            q1.push_front(3'(i));
                        end
            end else if (ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
        end
    endtask

    task automatic check_all();
        logic [2:0] e0;
        logic [2:0] e1;
        logic busy;
        busy = (q0.size() != 0);
        e0 = busy ? q0[0] : 3'd0;
        e1 = busy ? q1[0] : 3'd0;
        chk("lsb_in_ready",  {7'd0, bus0.in_ready},  {7'd0, !busy});
        chk("lsb_out_valid", {7'd0, bus0.out_valid}, {7'd0, busy});
        chk("lsb_index",     {5'd0, bus0.A, bus0.B, bus0.C}, {5'd0, e0});
        chk("lsb_out_last",  {7'd0, bus0.out_last},  {7'd0, q0.size() == 1});
        chk("lsb_zero_err",  {7'd0, bus0.zero_err},  {7'd0, zexp});
        chk("msb_in_ready",  {7'd0, bus1.in_ready},  {7'd0, !busy});
        chk("msb_out_valid", {7'd0, bus1.out_valid}, {7'd0, busy});
        chk("msb_index",     {5'd0, bus1.A, bus1.B, bus1.C}, {5'd0, e1});
        chk("msb_out_last",  {7'd0, bus1.out_last},  {7'd0, q1.size() == 1});
        chk("msb_zero_err",  {7'd0, bus1.zero_err},  {7'd0, zexp});
        if (busy) begin
            chk("lsb_decode_loop", 8'h01 << {bus0.A, bus0.B, bus0.C}, 8'h01 << e0);
            chk("msb_decode_loop", 8'h01 << {bus1.A, bus1.B, bus1.C}, 8'h01 << e1);
        end
    endtask

    task automatic cycle(input logic [7:0] vec, input logic valid, input logic ready, input logic rst);
        sys_rst = rst;
        bus0.in_vec = vec;  bus0.in_valid = valid;  bus0.out_ready = ready;
        bus1.in_vec = vec;  bus1.in_valid = valid;  bus1.out_ready = ready;
        #4;
        check_all();
        @(posedge sys_clk);
        model_step(vec, valid, ready, rst);
        #1;
    endtask

    initial begin
        bus0.in_vec = 8'h00; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_vec = 8'h00; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        model_step(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        sys_rst = 1'b0;
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(8'h01 << i, 1'b1, 1'b1, 1'b0);
            cycle(8'h00, 1'b0, 1'b1, 1'b0);
        end
        cycle(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h18, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle(8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h40, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 400; n++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            cycle(v, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
